alu74181_seq_ctrl: RTL
======================

Name: alu74181_seq_ctrl

Overview:
Multi-cycle controller that runs WIDTH-bit operations on a single external 4-bit 74181 ALU slice, one nibble per cycle, least-significant nibble first. Ripple carry between nibbles is done in time: Cn+4 from nibble i is registered and drives Cn for nibble i+1. Sits between the top-level pin mapping and the 74181 slice, and provides a start/busy/done handshake to the requester.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4. Local NIBBLES = WIDTH/4.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
op_a  in  WIDTH  operand A; latched on accepted start
op_b  in  WIDTH  operand B; latched on accepted start
sel  in  4  74181 S3..S0; latched on accepted start
mode  in  1  74181 M (1 = logic, 0 = arithmetic); latched
cin_n  in  1  carry-in, active-low (74181 Cn convention); latched
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse, result valid
result  out  WIDTH  assembled F; held until next accepted start
cout_n  out  1  final Cn+4, active-low
aeqb  out  1  AND of the slice A=B output over all nibbles
alu_a  out  4  nibble of latched A to the slice
alu_b  out  4  nibble of latched B to the slice
alu_s  out  4  latched sel
alu_m  out  1  latched mode
alu_cn  out  1  carry to the slice
alu_f  in  4  slice F output (combinational)
alu_cn4  in  1  slice Cn+4
alu_aeqb  in  1  slice A=B

Behaviour:
- Reset (async, rst=1): state IDLE; idx=0; all latches 0; result=0; cout_n=1; aeqb=0; busy=0; done=0. alu_* outputs follow the zeroed registers.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, latch op_a/op_b/sel/mode/cin_n, set idx=0, carry=cin_n, aeq_acc=1, then go to RUN. start=0 keeps IDLE.
- RUN, each cycle:
  - Drive alu_a=A[4*idx+3:4*idx] and alu_b likewise.
  - Drive alu_cn = carry when mode=0; alu_cn = latched cin_n when mode=1.
  - On the clock edge: result[4*idx+3:4*idx] <= alu_f; carry <= alu_cn4; aeq_acc <= aeq_acc & alu_aeqb.
  - If idx == NIBBLES-1, go to DONE; otherwise idx <= idx+1.
- DONE: done=1 for exactly one cycle. cout_n <= carry when mode=0, or 1 when mode=1. aeqb <= aeq_acc. Then return to IDLE.
- Latency: start accepted at edge 0; done high during cycle NIBBLES+1 (cycle 5 for WIDTH=16). Throughput: one op per NIBBLES+2 cycles.
- start while busy: ignored. Not queued, no effect on latched operands.
- Input operand changes while busy: no effect.
- start held high continuously: a new op is accepted on the first IDLE cycle after DONE.
- Reset mid-operation: immediate abort to the reset values; no done pulse.
- The slice is purely combinational; one cycle per nibble is sufficient by construction.
- WIDTH=4: single RUN cycle.

Optional Feature:
Macro ALU74181_SEQ_ZERO_EN.
- Defined: adds output port zero (1 bit, reset 0), updated in DONE as (final result == 0) and held until the next DONE.
- Not defined: port absent, no extra logic.

Test Plan:
The bench uses a behavioural 74181 model on the alu_* pins.
- WIDTH=16, sel=1001, mode=0, cin_n=1, A=0x1234, B=0x0FCD -> done at cycle 5, result=0x2201, cout_n=1.
- sel=1001, mode=0, cin_n=1, A=0xFFFF, B=0x0001 -> result=0x0000, cout_n=0; with macro, zero=1.
- sel=0110, mode=0, cin_n=0, A=0x5000, B=0x1000 -> result=0x4000, cout_n=0 (no borrow). Same with A=B=0x1234, cin_n=1 -> result=0xFFFF, aeqb=1.
- sel=0110, mode=1, A=0xA5A5, B=0xFFFF -> result=0x5A5A, cout_n=1, alu_cn equals cin_n in every RUN cycle.
- start pulsed again at cycle 2 with different operands -> ignored; first result unchanged; exactly one done pulse.
- rst asserted at cycle 3 of an op -> busy=0, result=0, no done; a subsequent op completes correctly.

Source files
------------

// File: rtl/alu74181_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu74181_seq_ctrl                                          |
// | Description : Nibble-serial controller driving one external 74181 slice, |
// |               LS nibble first, with the carry rippled through a register.|
// |               Optional macro ALU74181_SEQ_ZERO_EN adds a zero flag.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu74181_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       sel,
  input  logic             mode,
  input  logic             cin_n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_n,
  output logic             aeqb,
`ifdef ALU74181_SEQ_ZERO_EN
  output logic             zero,
`endif
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn,
  input  logic [3:0]       alu_f,
  input  logic             alu_cn4,
  input  logic             alu_aeqb
);

  localparam int c_NIBBLES = WIDTH / 4;
  localparam int c_IDX_W   = (c_NIBBLES > 1) ? $clog2(c_NIBBLES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [c_IDX_W-1:0] r_idx;
  logic [c_IDX_W+1:0] w_bit_base;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_sel;
  logic               r_mode;
  logic               r_cin_n;
  logic               r_carry;
  logic               r_aeq_acc;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout_n;
  logic               r_aeqb;
  logic               w_last;

  assign w_last     = (r_idx == c_LAST_IDX);
  assign w_bit_base = {r_idx, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sel     <= '0;
      r_mode    <= 1'b0;
      r_cin_n   <= 1'b0;
      r_carry   <= 1'b0;
      r_aeq_acc <= 1'b0;
      r_result  <= '0;
      r_cout_n  <= 1'b1;
      r_aeqb    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a       <= op_a;
            r_b       <= op_b;
            r_sel     <= sel;
            r_mode    <= mode;
            r_cin_n   <= cin_n;
            r_idx     <= '0;
            r_carry   <= cin_n;
            r_aeq_acc <= 1'b1;
          end
        end
        S_RUN: begin
          r_result[w_bit_base +: 4] <= alu_f;
          r_carry                   <= alu_cn4;
          r_aeq_acc                 <= r_aeq_acc & alu_aeqb;
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        S_DONE: begin
          // Logic mode produces no meaningful carry, so report "no carry".
          r_cout_n <= r_mode ? 1'b1 : r_carry;
          r_aeqb   <= r_aeq_acc;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU74181_SEQ_ZERO_EN
  logic r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_zero <= (r_result == '0);
    end
  end

  assign zero = r_zero;
`endif

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign cout_n = r_cout_n;
  assign aeqb   = r_aeqb;

  // Logic mode bypasses the rippled carry and feeds the original Cn to every nibble.
  assign alu_a  = r_a[w_bit_base +: 4];
  assign alu_b  = r_b[w_bit_base +: 4];
  assign alu_s  = r_sel;
  assign alu_m  = r_mode;
  assign alu_cn = r_mode ? r_cin_n : r_carry;

endmodule
`default_nettype wire
